// File: rtl/csr_bus_arbiter_pkg.sv
// Shared CSR package: address map, arbiter state encoding and owner codes.
// Imported by the arbiter and by anything that decodes owner_o.
package csr_bus_arbiter_pkg;

  // CSR address map (byte addresses)
  localparam logic [11:0] CSR_ADDR_CTRL    = 12'h000;
  localparam logic [11:0] CSR_ADDR_STATUS  = 12'h004;
  localparam logic [11:0] CSR_ADDR_ADC_CFG = 12'h010;
  localparam logic [11:0] CSR_ADDR_PLL_CFG = 12'h020;
  localparam logic [11:0] CSR_ADDR_LDO_CFG = 12'h030;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  localparam logic [1:0] OWNER_NONE = 2'd0;
  localparam logic [1:0] OWNER_M0   = 2'd1;
  localparam logic [1:0] OWNER_M1   = 2'd2;

  localparam logic LAST_M0 = 1'b0;
  localparam logic LAST_M1 = 1'b1;

  // Hold counter must reach MAX_HOLD; keep at least one bit when MAX_HOLD is 0.
  function automatic int hold_cnt_width(input int max_hold);
    return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/csr_bus_arbiter_if.sv
// Two-master CSR bus plus the single csr-block port behind the arbiter.
// slave = arbiter view, master = environment view (masters and csr block).
interface csr_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
);
  logic                  m0_req, m1_req;
  logic                  m0_stb, m1_stb;
  logic                  m0_we, m1_we;
  logic [ADDR_WIDTH-1:0] m0_addr, m1_addr;
  logic [DATA_WIDTH-1:0] m0_wdata, m1_wdata;
  logic                  m0_gnt, m1_gnt;
  logic [DATA_WIDTH-1:0] m0_rdata, m1_rdata;
  logic                  m0_rvalid, m1_rvalid;
  logic [ADDR_WIDTH-1:0] s_addr_o;
  logic                  s_ack_o;
  logic [DATA_WIDTH-1:0] s_data_o;
  logic [DATA_WIDTH-1:0] s_data_i;
  logic [1:0]            owner_o;

  modport slave (
    input  m0_req, m1_req, m0_stb, m1_stb, m0_we, m1_we,
           m0_addr, m1_addr, m0_wdata, m1_wdata, s_data_i,
    output m0_gnt, m1_gnt, m0_rdata, m1_rdata, m0_rvalid, m1_rvalid,
           s_addr_o, s_ack_o, s_data_o, owner_o
  );

  modport master (
    output m0_req, m1_req, m0_stb, m1_stb, m0_we, m1_we,
           m0_addr, m1_addr, m0_wdata, m1_wdata, s_data_i,
    input  m0_gnt, m1_gnt, m0_rdata, m1_rdata, m0_rvalid, m1_rvalid,
           s_addr_o, s_ack_o, s_data_o, owner_o
  );
endinterface

// File: rtl/csr_arb_rport.sv
// Per-master read return: captures csr read data of an accepted read and
// pulses rvalid one cycle later; rdata holds until the next read.
module csr_arb_rport #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_acc,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid
);
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;

  always_comb begin
    rvalid_d = rd_acc;
    rdata_d  = rd_acc ? rd_data : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
endmodule

// File: rtl/csr_bus_arbiter.sv
// Two-master CSR bus arbiter: round-robin on ties, one dead cycle between
// tenures, optional forced handover after MAX_HOLD accepted strobes.
module csr_bus_arbiter
  import csr_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_HOLD   = 64
) (
  input logic              clk,
  input logic              rst,
  csr_bus_arbiter_if.slave bus
);
  localparam int                HOLD_W   = hold_cnt_width(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  arb_state_e            state_q, state_d;
  logic                  last_q, last_d;
  logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic [ADDR_WIDTH-1:0] s_addr_q, s_addr_d;
  logic [DATA_WIDTH-1:0] s_data_q, s_data_d;

  logic                  gnt0, gnt1;
  logic                  acc0, acc1, acc_any, acc_we;
  logic                  rd0, rd1;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic                  hold_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last_q     <= LAST_M1;
      hold_cnt_q <= '0;
      s_addr_q   <= '0;
      s_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      s_addr_q   <= s_addr_d;
      s_data_q   <= s_data_d;
    end
  end

  // Handover is decided on the count including this cycle's strobe, so a
  // tenure never accepts more than MAX_HOLD strobes while the other waits.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    if (acc_any && (hold_cnt_q != HOLD_MAX)) hold_cnt_d = hold_cnt_q + HOLD_W'(1);
    hold_full  = (MAX_HOLD != 0) && (hold_cnt_d == HOLD_MAX);
    unique case (state_q)
      ST_IDLE: begin
        if (bus.m0_req && (!bus.m1_req || (last_q == LAST_M1))) begin
          state_d    = ST_OWN0;
          last_d     = LAST_M0;
          hold_cnt_d = '0;
        end else if (bus.m1_req) begin
          state_d    = ST_OWN1;
          last_d     = LAST_M1;
          hold_cnt_d = '0;
        end
      end
      ST_OWN0: if (!bus.m0_req || (hold_full && bus.m1_req)) state_d = ST_IDLE;
      ST_OWN1: if (!bus.m1_req || (hold_full && bus.m0_req)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes are gated by rst so an aborted tenure produces no slave activity.
  always_comb begin
    gnt0      = (state_q == ST_OWN0);
    gnt1      = (state_q == ST_OWN1);
    acc0      = gnt0 && bus.m0_stb && !rst;
    acc1      = gnt1 && bus.m1_stb && !rst;
    acc_any   = acc0 || acc1;
    acc_we    = acc0 ? bus.m0_we    : bus.m1_we;
    acc_addr  = acc0 ? bus.m0_addr  : bus.m1_addr;
    acc_wdata = acc0 ? bus.m0_wdata : bus.m1_wdata;
    rd0       = acc0 && !bus.m0_we;
    rd1       = acc1 && !bus.m1_we;
    s_addr_d  = acc_any ? acc_addr : s_addr_q;
    s_data_d  = (acc_any && acc_we) ? acc_wdata : s_data_q;

    bus.m0_gnt   = gnt0;
    bus.m1_gnt   = gnt1;
    bus.s_ack_o  = acc_any && acc_we;
    bus.s_addr_o = s_addr_d;
    bus.s_data_o = s_data_d;
    unique case (state_q)
      ST_OWN0: bus.owner_o = OWNER_M0;
      ST_OWN1: bus.owner_o = OWNER_M1;
      default: bus.owner_o = OWNER_NONE;
    endcase
  end

  csr_arb_rport #(.DATA_WIDTH(DATA_WIDTH)) u_rport0 (
    .clk     (clk),
    .rst     (rst),
    .rd_acc  (rd0),
    .rd_data (bus.s_data_i),
    .rdata   (bus.m0_rdata),
    .rvalid  (bus.m0_rvalid)
  );

  csr_arb_rport #(.DATA_WIDTH(DATA_WIDTH)) u_rport1 (
    .clk     (clk),
    .rst     (rst),
    .rd_acc  (rd1),
    .rd_data (bus.s_data_i),
    .rdata   (bus.m1_rdata),
    .rvalid  (bus.m1_rvalid)
  );
endmodule

// File: tb/tb_csr_bus_arbiter.sv
// Scoreboard bench: two arbiters (MAX_HOLD 4 and 0) share one stimulus stream;
// a tenure-level model queues expected bus activity, a monitor checks it.
module tb_csr_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        i_r0 = 0, i_r1 = 0, i_s0 = 0, i_s1 = 0, i_w0 = 0, i_w1 = 0;
  logic [11:0] i_a0 = 0, i_a1 = 0;
  logic [7:0]  i_d0 = 0, i_d1 = 0;

  csr_bus_arbiter_if #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) bh ();
  csr_bus_arbiter_if #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) bz ();

  csr_bus_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .MAX_HOLD(4)) dut_h (
    .clk(clk), .rst(rst), .bus(bh));
  csr_bus_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .MAX_HOLD(0)) dut_z (
    .clk(clk), .rst(rst), .bus(bz));

  // csr block: read data is a fixed function of the address (0x020 -> 0xA5)
  function automatic logic [7:0] csr_val(input logic [11:0] a);
    return a[7:0] ^ 8'h85 ^ {4'h0, a[11:8]};
  endfunction

  assign bh.m0_req = i_r0;  assign bz.m0_req = i_r0;
  assign bh.m1_req = i_r1;  assign bz.m1_req = i_r1;
  assign bh.m0_stb = i_s0;  assign bz.m0_stb = i_s0;
  assign bh.m1_stb = i_s1;  assign bz.m1_stb = i_s1;
  assign bh.m0_we = i_w0;   assign bz.m0_we = i_w0;
  assign bh.m1_we = i_w1;   assign bz.m1_we = i_w1;
  assign bh.m0_addr = i_a0; assign bz.m0_addr = i_a0;
  assign bh.m1_addr = i_a1; assign bz.m1_addr = i_a1;
  assign bh.m0_wdata = i_d0; assign bz.m0_wdata = i_d0;
  assign bh.m1_wdata = i_d1; assign bz.m1_wdata = i_d1;
  assign bh.s_data_i = csr_val(bh.s_addr_o);
  assign bz.s_data_i = csr_val(bz.s_addr_o);

  logic [1:0]  o_owner[2];
  logic        o_gnt[2][2], o_rv[2][2], o_ack[2];
  logic [11:0] o_addr[2];
  logic [7:0]  o_data[2], o_rd[2][2];

  assign o_owner[0] = bh.owner_o;   assign o_owner[1] = bz.owner_o;
  assign o_gnt[0][0] = bh.m0_gnt;   assign o_gnt[0][1] = bh.m1_gnt;
  assign o_gnt[1][0] = bz.m0_gnt;   assign o_gnt[1][1] = bz.m1_gnt;
  assign o_rv[0][0] = bh.m0_rvalid; assign o_rv[0][1] = bh.m1_rvalid;
  assign o_rv[1][0] = bz.m0_rvalid; assign o_rv[1][1] = bz.m1_rvalid;
  assign o_rd[0][0] = bh.m0_rdata;  assign o_rd[0][1] = bh.m1_rdata;
  assign o_rd[1][0] = bz.m0_rdata;  assign o_rd[1][1] = bz.m1_rdata;
  assign o_ack[0] = bh.s_ack_o;     assign o_ack[1] = bz.s_ack_o;
  assign o_addr[0] = bh.s_addr_o;   assign o_addr[1] = bz.s_addr_o;
  assign o_data[0] = bh.s_data_o;   assign o_data[1] = bz.s_data_o;

  typedef struct {
    int         cyc;
    logic       chk;
    logic [1:0] owner;
    logic       ack;
    logic [11:0] addr;
    logic [7:0] data;
    logic [7:0] rd0;
    logic [7:0] rd1;
  } crec_t;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } rrec_t;

  crec_t cq[2][$];
  rrec_t rq[2][2][$];

  // Reference model: owner 0 = none, 1 = m0, 2 = m1; last = last owner.
  int          own[2]  = '{0, 0};
  int          last[2] = '{2, 2};
  int          cnt[2]  = '{0, 0};
  int          mh[2]   = '{4, 0};
  logic [11:0] sh_a[2] = '{12'h0, 12'h0};
  logic [7:0]  sh_d[2] = '{8'h0, 8'h0};
  logic [7:0]  lrd[2][2];
  bit          mvalid = 0;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc %0d: got %0h expected %0h", name, k, cyc, act, exp);
    end
  endtask

  task automatic step(input bit r0, input bit r1, input bit s0, input bit s1,
                      input bit w0, input bit w1, input logic [11:0] a0, input logic [11:0] a1,
                      input logic [7:0] d0, input logic [7:0] d1, input bit rs);
    @(posedge clk);
    #1;
    i_r0 = r0; i_r1 = r1; i_s0 = s0; i_s1 = s1; i_w0 = w0; i_w1 = w1;
    i_a0 = a0; i_a1 = a1; i_d0 = d0; i_d1 = d1; rst = rs;
    for (int k = 0; k < 2; k++) begin
      crec_t r;
      rrec_t rr;
      int am;
      int w;
      bit mine, other;
      r.cyc = cyc; r.chk = mvalid; r.owner = 2'(own[k]);
      r.rd0 = lrd[k][0]; r.rd1 = lrd[k][1]; r.ack = 1'b0;
      am = -1;
      if (!rs && own[k] == 1 && s0) am = 0;
      else if (!rs && own[k] == 2 && s1) am = 1;
      if (am >= 0) begin
        sh_a[k] = (am == 0) ? a0 : a1;
        if ((am == 0) ? w0 : w1) begin
          r.ack = 1'b1;
          sh_d[k] = (am == 0) ? d0 : d1;
        end else begin
          rr.cyc = cyc + 1;
          rr.data = csr_val(sh_a[k]);
          rq[k][am].push_back(rr);
          lrd[k][am] = rr.data;
        end
      end
      r.addr = sh_a[k]; r.data = sh_d[k];
      cq[k].push_back(r);
      if (rs) begin
        own[k] = 0; last[k] = 2; cnt[k] = 0; sh_a[k] = 0; sh_d[k] = 0;
        lrd[k][0] = 0; lrd[k][1] = 0;
      end else if (own[k] == 0) begin
        w = 0;
        if (r0 && r1) w = (last[k] == 1) ? 2 : 1;
        else if (r0) w = 1;
        else if (r1) w = 2;
        if (w != 0) begin own[k] = w; last[k] = w; cnt[k] = 0; end
      end else begin
        if (am >= 0 && cnt[k] < mh[k]) cnt[k]++;
        mine  = (own[k] == 1) ? r0 : r1;
        other = (own[k] == 1) ? r1 : r0;
        if (!mine || (mh[k] != 0 && cnt[k] == mh[k] && other)) own[k] = 0;
      end
    end
    if (rs) mvalid = 1;
  endtask

  task automatic idle(input int n, input bit r0, input bit r1);
    repeat (n) step(r0, r1, 0, 0, 0, 0, 12'h0, 12'h0, 8'h0, 8'h0, 0);
  endtask

  // Monitor: per-cycle bus expectations, plus pop-on-rvalid for read data.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      crec_t r;
      rrec_t rr;
      if (cq[k].size() != 0) begin
        r = cq[k].pop_front();
        if (r.chk) begin
          chk("owner", k, 32'(o_owner[k]), 32'(r.owner));
          chk("m0_gnt", k, 32'(o_gnt[k][0]), 32'(r.owner == 2'd1));
          chk("m1_gnt", k, 32'(o_gnt[k][1]), 32'(r.owner == 2'd2));
          chk("s_ack", k, 32'(o_ack[k]), 32'(r.ack));
          chk("s_addr", k, 32'(o_addr[k]), 32'(r.addr));
          chk("s_data", k, 32'(o_data[k]), 32'(r.data));
          chk("m0_rdata_hold", k, 32'(o_rd[k][0]), 32'(r.rd0));
          chk("m1_rdata_hold", k, 32'(o_rd[k][1]), 32'(r.rd1));
        end
      end
      for (int m = 0; m < 2; m++) begin
        while (rq[k][m].size() != 0 && rq[k][m][0].cyc < cyc) begin
          rr = rq[k][m].pop_front();
          n_tests++; n_fail++;
          $display("FAIL rvalid_missing dut%0d m%0d: no rvalid seen, required at cyc %0d", k, m, rr.cyc);
        end
        if (o_rv[k][m] === 1'b1) begin
          if (rq[k][m].size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL rvalid_unexpected dut%0d m%0d cyc %0d: got rvalid 1 expected 0", k, m, cyc);
          end else begin
            rr = rq[k][m].pop_front();
            chk("rvalid_cyc", k, 32'(cyc), 32'(rr.cyc));
            chk("rdata", k, 32'(o_rd[k][m]), 32'(rr.data));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  bit rr0 = 0, rr1 = 0;

  initial begin
    lrd[0][0] = 0; lrd[0][1] = 0; lrd[1][0] = 0; lrd[1][1] = 0;
    repeat (2) step(0, 0, 0, 0, 0, 0, 12'h0, 12'h0, 8'h0, 8'h0, 1);
    // simultaneous request after reset, m0 releases, m1 follows after dead cycle
    idle(3, 1, 1);
    idle(4, 0, 1);
    idle(2, 0, 0);
    // m0 write while m1 strobes without grant
    idle(2, 1, 0);
    step(1, 0, 1, 1, 1, 1, 12'h010, 12'h0FF, 8'h5A, 8'h33, 0);
    step(1, 0, 0, 1, 0, 1, 12'h000, 12'h0EE, 8'h00, 8'h44, 0);
    idle(2, 0, 0);
    // m1 read
    idle(2, 0, 1);
    step(0, 1, 0, 1, 0, 0, 12'h000, 12'h020, 8'h00, 8'h00, 0);
    idle(2, 0, 1);
    idle(2, 0, 0);
    // m0 streaming with m1 waiting
    for (int i = 0; i < 10; i++)
      step(1, 1, 1, 0, 1, 0, 12'(12'h100 + i), 12'h0, 8'(i), 8'h0, 0);
    idle(3, 0, 1);
    idle(2, 0, 0);
    // long m0 tenure with m1 requesting; alternating writes and reads
    for (int i = 0; i < 1000; i++)
      step(1, 1, 1, 1, 1'(i), 1'(i), 12'(i), 12'(i + 7), 8'(i * 3), 8'(i), 0);
    idle(3, 0, 1);
    idle(2, 0, 0);
    // reset pulse during an m1 write burst, then tie goes to m0
    idle(2, 0, 1);
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 1, 0, 1, 12'h0, 12'(12'h200 + i), 8'h0, 8'(8'hC0 + i), 0);
    step(0, 1, 0, 1, 0, 1, 12'h0, 12'h2FF, 8'h0, 8'hEE, 1);
    idle(3, 1, 1);
    idle(2, 0, 0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) rr0 = !rr0;
      if ($urandom_range(7) == 0) rr1 = !rr1;
      step(rr0, rr1, $urandom_range(3) != 0, $urandom_range(3) != 0,
           1'($urandom_range(1)), 1'($urandom_range(1)),
           12'($urandom), 12'($urandom), 8'($urandom), 8'($urandom), 0);
    end
    idle(4, 0, 0);
    @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("cq_drained", k, 32'(cq[k].size()), 32'd0);
      for (int m = 0; m < 2; m++) chk("rq_drained", k, 32'(rq[k][m].size()), 32'd0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/csr_bus_arbiter.md
CSR_BUS_ARBITER -- requirements
Module: csr_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, the CSR byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, the CSR data width.
REQ-003 SHALL have parameter MAX_HOLD, default 64, the strobes allowed per tenure before forced handover; 0 disables forced handover.
REQ-004 SHALL have port clk, input, 1, the clock.
REQ-005 SHALL have port rst, input, 1, a synchronous, active-high reset.
REQ-006 SHALL have ports m0_req and m1_req, input, 1 each, the bus request, held for the whole burst.
REQ-007 SHALL have ports m0_stb and m1_stb, input, 1 each, the single-cycle access strobe.
REQ-008 SHALL have ports m0_we and m1_we, input, 1 each, the write enable, qualified by stb.
REQ-009 SHALL have ports m0_addr and m1_addr, input, ADDR_WIDTH each, the access address, qualified by stb.
REQ-010 SHALL have ports m0_wdata and m1_wdata, input, DATA_WIDTH each, the write data, qualified by stb.
REQ-011 SHALL have ports m0_gnt and m1_gnt, output, 1 each, the registered grant.
REQ-012 SHALL have ports m0_rdata and m1_rdata, output, DATA_WIDTH each, the registered read data.
REQ-013 SHALL have ports m0_rvalid and m1_rvalid, output, 1 each, a one-cycle read-data-valid pulse.
REQ-014 SHALL have port s_addr_o, output, ADDR_WIDTH, the address to the csr block.
REQ-015 SHALL have port s_ack_o, output, 1, the write strobe to the csr block.
REQ-016 SHALL have port s_data_o, output, DATA_WIDTH, the write data to the csr block.
REQ-017 SHALL have port s_data_i, input, DATA_WIDTH, the combinational read data from the csr block at s_addr_o.
REQ-018 SHALL have port owner_o, output, 2, the current owner: 0 = none, 1 = m0, 2 = m1.

Function
REQ-019 SHALL implement the FSM states IDLE, OWN0 and OWN1; gnt and owner_o SHALL be decoded from the state register only.
REQ-020 IDLE SHALL go to OWN0 if only m0_req, to OWN1 if only m1_req, and if both SHALL grant the master not in last_ff (the last-owner pointer).
REQ-021 Grant latency SHALL be 1 cycle: req sampled high in IDLE -> gnt high on the next cycle.
REQ-022 OWNx SHALL go to IDLE when mx_req is low; gnt SHALL drop on the next edge and IDLE SHALL last at least one cycle (one dead cycle between tenures).
REQ-023 On entering OWNx, last_ff SHALL be set to x and hold_cnt SHALL be cleared.
REQ-024 hold_cnt SHALL increment on each accepted strobe and saturate at MAX_HOLD.
REQ-025 When MAX_HOLD != 0, hold_cnt == MAX_HOLD and the other master requests, OWNx SHALL go to IDLE even if mx_req stays high; the other master SHALL win the next arbitration.
REQ-026 A strobe SHALL be accepted only from the master whose gnt is high in that cycle; other strobes SHALL be dropped silently with no slave activity.
REQ-027 An accepted write SHALL drive s_addr_o, s_data_o and s_ack_o = 1 in the same cycle (combinational mux from the owner).
REQ-028 An accepted read SHALL drive s_addr_o, sample s_data_i into mx_rdata and pulse mx_rvalid on the next cycle.
REQ-029 When no strobe is accepted, s_ack_o SHALL be 0 and s_addr_o/s_data_o SHALL hold their last values (registered shadow).
REQ-030 A strobe in the last granted cycle of a tenure SHALL still be completed, including its rvalid.
REQ-031 Simultaneous release by one master and request by the other SHALL still pass through IDLE.
REQ-032 mx_rdata SHALL hold its value until the next read by that master.

Reset
REQ-033 rst SHALL force state IDLE, last_ff = m1 (so m0 wins the first tie), hold_cnt = 0, all gnt/rvalid/s_ack_o = 0, and rdata/s_addr_o/s_data_o = 0.
REQ-034 rst asserted mid-tenure SHALL abort it with no s_ack_o in the reset cycle or after, and no rvalid for a pending read.

Structure
REQ-035 Constants for the state encoding and owner_o codes SHALL live in the shared csr package next to the csr address map.
REQ-036 Implementation SHALL be a single module; the per-master read-return path MAY be one sub-module csr_arb_rport instantiated twice.

Verification
REQ-037 Both req rise together after reset -> m0_gnt at +1 cycle; m0 releases -> 1 dead cycle -> m1_gnt.
REQ-038 m0 writes addr 0x010 data 0x5A -> s_ack_o = 1 with s_addr_o = 0x010 and s_data_o = 0x5A in that cycle; m1_stb during m0 tenure -> no s_ack_o.
REQ-039 m1 reads addr 0x020 with s_data_i = 0xA5 -> m1_rvalid one cycle later and m1_rdata = 0xA5.
REQ-040 MAX_HOLD = 4, m0 streaming strobes with m1_req high -> exactly 4 accepted, then IDLE, then m1_gnt.
REQ-041 rst pulse during an m1 write burst -> all outputs at reset values next cycle and m0 wins the following tie.
REQ-042 MAX_HOLD = 0, m0 holds req for 1000 strobes with m1 requesting -> m1 never granted until m0 releases.
